timer_share_ctrl: RTL and testbench
===================================

# timer_share_ctrl

Round-robin scheduler that shares one loadable N-bit down-counter between several requesters. Each requester asks for a countdown of a programmable length. The controller grants one requester at a time, loads the counter, runs it to zero, pulses a per-requester done, then moves priority on. It sits between the binary-counter primitives and client blocks that need timed delays but cannot each afford a private counter.

## Interface
- NREQ, 4: number of requesters (2..8).
- W, 8: counter width in bits; lengths are W-bit unsigned.
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; held until the matching done pulse.
- len  in  NREQ*W  packed lengths; requester i owns bits [i*W +: W]; sampled only in the grant cycle.
- abort  in  1  synchronous cancel of the running countdown.
- gnt  out  NREQ  one-hot grant of the current owner; all zero when idle.
- busy  out  1  high in RUN and DONE.
- done  out  NREQ  one-cycle pulse to the owner on normal completion.
- count_out  out  W  live counter value.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, any req bit high: select the winner, load counter with len[winner], set gnt[winner], go to RUN.
- Winner selection: search upward from pointer ptr with wrap (ptr, ptr+1, … NREQ-1, 0, …). First set req bit wins.
- RUN, count_out != 0 and abort low: decrement by 1.
- RUN, count_out == 0 and abort low: go to DONE and set done[owner].
- DONE: clear done and gnt, set ptr = owner+1 mod NREQ, go to IDLE. DONE lasts exactly one cycle.
- abort in RUN (any count): go to IDLE next edge. gnt clears, no done pulse, ptr = owner+1, count_out freezes at its current value. abort is ignored in IDLE and DONE.
- req dropped during RUN: ignored; the countdown completes and done still pulses.
- req still high after DONE: eligible again, but only after the other pending requesters (ptr has moved past it).
- len = 0: a legal countdown that produces the shortest job.
- Counter never wraps below zero; it is only decremented in RUN when nonzero.
- Reset values: state IDLE, gnt 0, done 0, busy 0, ptr 0, count_out all ones. count_out holds its value in IDLE and DONE.
- Reset mid-operation: everything returns to reset values immediately; no done pulse.

## Timing
- Grant edge E0 (IDLE with req): after E0, gnt and busy are high and count_out = L.
- After edge E_k (k ≤ L), count_out = L−k.
- After E_{L+1}: state DONE, done[owner] = 1, count_out = 0.
- After E_{L+2}: state IDLE, gnt, busy and done all 0.
- The earliest next grant is edge E_{L+3}.
- Job occupancy is L+3 cycles from grant edge to next possible grant edge.
- Requester response window: the requester sees done during cycle E_{L+1}..E_{L+2} and must drop req before edge E_{L+3} to avoid re-arbitration.

## Structure
- Shared package timer_share_pkg holds:
  - state_t enum (IDLE, RUN, DONE);
  - default NREQ and W constants.
- Sub-module ld_dn_counter (parameter W): ports clk, rstn, load, load_val, en, count_out, zero. Resets count_out to all ones; load has priority over en; decrements only when en and not zero.
- The controller holds the FSM, ptr, owner index, the round-robin search and the gnt/done registers.

## Test plan
- Single request: req[1]=1, len1=5. Expected: gnt=0010 after E0; count_out steps 5..0; done[1] pulses after E6; idle after E7.
- Zero length: req[0]=1, len0=0. Expected: count_out=0 after E0, done[0] after E1, gnt clears after E2.
- Fairness: all four req held high, all lengths 2. Expected grants in order 0,1,2,3,0, each grant 5 cycles apart, exactly one done per grant.
- Abort: req[2], len=10; abort pulsed when count_out=6. Expected: IDLE next edge, count_out holds 6, no done, next grant goes to requester 3 if it is pending.
- Async reset mid-run: rstn low while count_out=3. Expected: immediate gnt=0, busy=0, done=0, count_out=all ones; after release, a new req is granted from ptr=0.
- Dropped request: req[3] deasserted at count_out=4. Expected: the countdown continues and done[3] still pulses.

Source files
------------

// File: rtl/timer_share_pkg.sv
// timer_share_pkg: shared FSM state type and default sizes for the timer share controller
package timer_share_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_W = 8;
endpackage

// File: rtl/timer_share_ctrl_if.sv
// timer_share_ctrl_if: request/grant bundle between client blocks and the shared timer controller
interface timer_share_ctrl_if import timer_share_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int W = DEF_W
);
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] len;
  logic abort;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic [NREQ-1:0] done;
  logic [W-1:0] count_out;
  modport master(output req, len, abort, input gnt, busy, done, count_out);
  modport slave(input req, len, abort, output gnt, busy, done, count_out);
endinterface

// File: rtl/ld_dn_counter.sv
// ld_dn_counter: loadable down-counter that stops at zero; load wins over enable
module ld_dn_counter import timer_share_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic [W-1:0] load_val,
  input  logic en,
  output logic [W-1:0] count_out,
  output logic zero
);
  logic [W-1:0] count_q, count_d;
  assign zero = count_q == '0;
  assign count_out = count_q;
  // next count: load, else decrement unless already at zero
  always_comb count_d = load ? load_val : (en && !zero) ? count_q - 1'b1 : count_q;
  // counter register, all ones out of reset
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) count_q <= '1;
    else count_q <= count_d;
endmodule

// File: rtl/timer_share_ctrl.sv
// timer_share_ctrl: round-robin arbiter sharing one down-counter among NREQ requesters
module timer_share_ctrl import timer_share_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int W = DEF_W
) (
  input logic clk,
  input logic rstn,
  timer_share_ctrl_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, win, nxt;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic found, load, en, zero;
  logic [W-1:0] cnt;
  assign nxt = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = state_q != IDLE;
  assign bus.count_out = cnt;
  ld_dn_counter #(.W(W)) u_cnt (
    .clk(clk),
    .rstn(rstn),
    .load(load),
    .load_val(bus.len[int'(win)*W +: W]),
    .en(en),
    .count_out(cnt),
    .zero(zero)
  );
  // first requester at or after ptr, wrapping; lowest offset wins
  always_comb begin : rr_search
    int idx;
    found = 1'b0;
    win = ptr_q;
    idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx -= NREQ;
      if (bus.req[idx]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
  end
  // grant, count down, pulse done, then advance priority past the owner
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    gnt_d = gnt_q;
    done_d = '0;
    load = 1'b0;
    en = 1'b0;
    if (state_q == IDLE && found) begin
      state_d = RUN;
      owner_d = win;
      gnt_d = NREQ'(1) << win;
      load = 1'b1;
    end else if (state_q == RUN) begin
      if (bus.abort) begin
        state_d = IDLE;
        gnt_d = '0;
        ptr_d = nxt;
      end else if (zero) begin
        state_d = DONE;
        done_d = gnt_q;
      end else en = 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      gnt_d = '0;
      ptr_d = nxt;
    end
  end
  // controller state registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_timer_share_ctrl.sv
// tb_timer_share_ctrl: scoreboard bench for the shared timer controller
module tb_timer_share_ctrl;
  import timer_share_pkg::*;
  localparam int N = DEF_NREQ;
  localparam int WD = DEF_W;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_gnt_q[$];
  logic [WD-1:0] exp_len_q[$];
  logic [N-1:0] exp_done_q[$];
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] mon_g;
  logic [WD-1:0] mon_l;

  timer_share_ctrl_if #(.NREQ(N), .W(WD)) tif();
  timer_share_ctrl #(.NREQ(N), .W(WD)) dut (.clk(clk), .rstn(rstn), .bus(tif));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [WD-1:0] v);
    tif.len[i*WD +: WD] = v;
  endtask

  task automatic push(input int i, input logic [WD-1:0] l, input bit with_done);
    exp_gnt_q.push_back(oh(i));
    exp_len_q.push_back(l);
    if (with_done) exp_done_q.push_back(oh(i));
  endtask

  // scoreboard: every new grant and every done pulse is matched against the queues
  always @(negedge clk) begin
    if (tif.gnt != '0 && prev_gnt == '0) begin
      checks++;
      if (exp_gnt_q.size() == 0) begin
        errors++;
        $display("FAIL sb_grant: got gnt=%b, required no grant", tif.gnt);
      end else begin
        mon_g = exp_gnt_q.pop_front();
        mon_l = exp_len_q.pop_front();
        if (tif.gnt !== mon_g || tif.count_out !== mon_l) begin
          errors++;
          $display("FAIL sb_grant: got gnt=%b count=%0d, required gnt=%b count=%0d", tif.gnt, tif.count_out, mon_g, mon_l);
        end
      end
    end
    if (tif.done != '0) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL sb_done: got done=%b, required no done", tif.done);
      end else begin
        mon_g = exp_done_q.pop_front();
        if (tif.done !== mon_g) begin
          errors++;
          $display("FAIL sb_done: got done=%b, required %b", tif.done, mon_g);
        end
      end
    end
    prev_gnt = tif.gnt;
  end

  task automatic test_reset();
    tif.req = '0;
    tif.len = '0;
    tif.abort = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (tif.gnt !== '0 || tif.busy !== 1'b0 || tif.done !== '0) begin
      errors++;
      $display("FAIL reset_outs: got gnt=%b busy=%b done=%b, required 0 0 0", tif.gnt, tif.busy, tif.done);
    end
    checks++;
    if (tif.count_out !== '1) begin
      errors++;
      $display("FAIL reset_count: got %0d, required %0d", tif.count_out, 8'hff);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (tif.count_out !== '1 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got count=%0d busy=%b, required 255 0", tif.count_out, tif.busy);
    end
  endtask

  task automatic test_single();
    set_len(1, 5);
    tif.req = 4'b0010;
    push(1, 5, 1);
    tick();
    checks++;
    if (tif.gnt !== 4'b0010 || tif.busy !== 1'b1 || tif.count_out !== 8'd5) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b busy=%b count=%0d, required 0010 1 5", tif.gnt, tif.busy, tif.count_out);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (tif.count_out !== WD'(5 - k) || tif.done !== '0) begin
        errors++;
        $display("FAIL single_step: got count=%0d done=%b, required %0d 0000", tif.count_out, tif.done, 5 - k);
      end
    end
    tick();
    checks++;
    if (tif.done !== 4'b0010 || tif.count_out !== 8'd0 || tif.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got done=%b count=%0d busy=%b, required 0010 0 1", tif.done, tif.count_out, tif.busy);
    end
    tif.req = '0;
    tick();
    checks++;
    if (tif.gnt !== '0 || tif.busy !== 1'b0 || tif.done !== '0) begin
      errors++;
      $display("FAIL single_idle: got gnt=%b busy=%b done=%b, required 0 0 0", tif.gnt, tif.busy, tif.done);
    end
  endtask

  task automatic test_zero_len();
    set_len(0, 0);
    tif.req = 4'b0001;
    push(0, 0, 1);
    tick();
    checks++;
    if (tif.gnt !== 4'b0001 || tif.count_out !== 8'd0) begin
      errors++;
      $display("FAIL zero_grant: got gnt=%b count=%0d, required 0001 0", tif.gnt, tif.count_out);
    end
    tick();
    checks++;
    if (tif.done !== 4'b0001) begin
      errors++;
      $display("FAIL zero_done: got done=%b, required 0001", tif.done);
    end
    tif.req = '0;
    tick();
    checks++;
    if (tif.gnt !== '0 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got gnt=%b busy=%b, required 0000 0", tif.gnt, tif.busy);
    end
  endtask

  task automatic test_async_reset();
    set_len(2, 5);
    tif.req = 4'b0100;
    push(2, 5, 0);
    tick();
    tick();
    tick();
    checks++;
    if (tif.count_out !== 8'd3 || tif.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL ar_pre: got count=%0d gnt=%b, required 3 0100", tif.count_out, tif.gnt);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (tif.gnt !== '0 || tif.busy !== 1'b0 || tif.done !== '0 || tif.count_out !== '1) begin
      errors++;
      $display("FAIL ar_clear: got gnt=%b busy=%b done=%b count=%0d, required 0 0 0 255", tif.gnt, tif.busy, tif.done, tif.count_out);
    end
    tif.req = '0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_fairness();
    int ng, nd, last;
    logic [N-1:0] pg;
    ng = 0;
    nd = 0;
    last = -1;
    for (int i = 0; i < N; i++) set_len(i, 2);
    for (int g = 0; g < 5; g++) push(g % N, 2, 1);
    tif.req = '1;
    pg = tif.gnt;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (tif.done != '0) nd++;
      if (tif.gnt != '0 && pg == '0) begin
        if (ng > 0) begin
          checks++;
          if (c - last != 5) begin
            errors++;
            $display("FAIL fair_spacing: got %0d cycles, required 5", c - last);
          end
        end
        last = c;
        ng++;
        if (ng == 5) tif.req = '0;
      end
      pg = tif.gnt;
    end
    checks++;
    if (ng != 5 || nd != 5 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL fair_totals: got grants=%0d dones=%0d busy=%b, required 5 5 0", ng, nd, tif.busy);
    end
  endtask

  task automatic test_abort();
    set_len(2, 10);
    set_len(3, 3);
    tif.req = 4'b1100;
    push(2, 10, 0);
    push(3, 3, 1);
    tick();
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (tif.count_out !== 8'd6 || tif.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL abort_pre: got count=%0d gnt=%b, required 6 0100", tif.count_out, tif.gnt);
    end
    tif.abort = 1'b1;
    tick();
    tif.abort = 1'b0;
    tif.req = 4'b1000;
    checks++;
    if (tif.gnt !== '0 || tif.busy !== 1'b0 || tif.done !== '0 || tif.count_out !== 8'd6) begin
      errors++;
      $display("FAIL abort_stop: got gnt=%b busy=%b done=%b count=%0d, required 0 0 0 6", tif.gnt, tif.busy, tif.done, tif.count_out);
    end
    tick();
    checks++;
    if (tif.gnt !== 4'b1000 || tif.count_out !== 8'd3) begin
      errors++;
      $display("FAIL abort_next: got gnt=%b count=%0d, required 1000 3", tif.gnt, tif.count_out);
    end
    for (int k = 0; k < 3; k++) tick();
    tick();
    checks++;
    if (tif.done !== 4'b1000) begin
      errors++;
      $display("FAIL abort_next_done: got done=%b, required 1000", tif.done);
    end
    tif.req = '0;
    tick();
  endtask

  task automatic test_dropped();
    set_len(3, 6);
    tif.req = 4'b1000;
    push(3, 6, 1);
    tick();
    tick();
    tick();
    checks++;
    if (tif.count_out !== 8'd4) begin
      errors++;
      $display("FAIL drop_pre: got count=%0d, required 4", tif.count_out);
    end
    tif.req = '0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (tif.count_out !== 8'd0 || tif.gnt !== 4'b1000 || tif.busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_run: got count=%0d gnt=%b busy=%b, required 0 1000 1", tif.count_out, tif.gnt, tif.busy);
    end
    tick();
    checks++;
    if (tif.done !== 4'b1000) begin
      errors++;
      $display("FAIL drop_done: got done=%b, required 1000", tif.done);
    end
    tick();
    checks++;
    if (tif.gnt !== '0 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got gnt=%b busy=%b, required 0000 0", tif.gnt, tif.busy);
    end
  endtask

  task automatic test_drain();
    tick();
    tick();
    checks++;
    if (exp_gnt_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d grants %0d dones outstanding, required 0 0", exp_gnt_q.size(), exp_done_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_async_reset();
    test_fairness();
    test_abort();
    test_dropped();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
